// File: rtl/hdmi_pkg.sv
// hdmi_pkg: shared widths and state encoding for the HDMI frame capture block.
//   PIXEL_W          bits per RGB pixel
//   AXIS_W           bits per output stream word
//   PIXELS_PER_GROUP pixels that pack into a whole number of words
//   WORDS_PER_GROUP  words produced by one pixel group
//   RESID_W          widest residual the packer can hold (7 bytes)
//   PACK_W           residual plus one incoming pixel
package hdmi_pkg;

    localparam int unsigned PIXEL_W          = 24;
    localparam int unsigned AXIS_W           = 64;
    localparam int unsigned PIXELS_PER_GROUP = 8;
    localparam int unsigned WORDS_PER_GROUP  = 3;
    localparam int unsigned RESID_W          = AXIS_W - 8;
    localparam int unsigned PACK_W           = RESID_W + PIXEL_W;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCapture = 2'd1,
        StDrop    = 2'd2
    } cap_state_e;

endpackage

// File: rtl/axis_word_fifo.sv
// axis_word_fifo: small synchronous FIFO for packed stream words.
//   clk, rst      clock and asynchronous active-high reset
//   wr_valid      push request, wr_data payload, wr_ready push accepted this cycle
//   rd_valid      head entry present, rd_data head entry, rd_ready consumer pops
// The read side is taken straight from storage flops (zero when empty), so no
// combinational path from wr_* reaches rd_*. A push into a full FIFO is accepted
// when the head is popped in the same cycle.
module axis_word_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 66
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    input  logic             rd_ready
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PtrW:0] Full = (PtrW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [PtrW:0]    count_q;
    logic             push;
    logic             pop;

    assign rd_valid = (count_q != '0);
    assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
    assign pop      = rd_valid && rd_ready;
    assign wr_ready = (count_q != Full) || rd_ready;
    assign push     = wr_valid && wr_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wr_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/hdmi_capture.sv
// hdmi_capture: captures active-area pixels of a video frame, packs them
// little-endian and byte-continuous into 64-bit words and streams them out over
// AXI-Stream with tuser on the first word and tlast on the last word of a frame.
//   aclk, areset                 clock, asynchronous active-high reset
//   rgb, cx, cy                  pixel and its coordinates
//   screen_width, screen_height  active area size (width a multiple of 8)
//   enable                       capture request, looked at only on start of frame
//   m_axis_rgb_*                 output stream (tdata, tvalid, tready, tlast, tuser)
//   overflow                     one-cycle pulse per aborted frame
//   dropped_frames               saturating count of aborted frames
module hdmi_capture
    import hdmi_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic [PIXEL_W-1:0] rgb,
    input  logic [9:0]        cx,
    input  logic [9:0]        cy,
    input  logic [9:0]        screen_width,
    input  logic [9:0]        screen_height,
    input  logic              enable,
    output logic [AXIS_W-1:0] m_axis_rgb_tdata,
    output logic              m_axis_rgb_tvalid,
    input  logic              m_axis_rgb_tready,
    output logic              m_axis_rgb_tlast,
    output logic              m_axis_rgb_tuser,
    output logic              overflow,
    output logic [15:0]       dropped_frames
);

    localparam int unsigned FifoW = AXIS_W + 2;

    cap_state_e         state_q, state_d;
    logic [RESID_W-1:0] resid_q, resid_d;
    logic [2:0]         cnt_q, cnt_d;
    logic               first_q, first_d;
    logic               push_valid_q, push_valid_d;
    logic [AXIS_W-1:0]  push_data_q, push_data_d;
    logic               push_last_q, push_last_d;
    logic               push_user_q, push_user_d;
    logic               overflow_q, overflow_d;
    logic [15:0]        dropped_q, dropped_d;

    logic               sof;
    logic               video;
    logic               last_pix;
    logic               fifo_ready;
    logic               push_fail;
    logic               tail_push;
    logic               abort;
    logic               start;
    logic               take;
    logic [2:0]         cnt_base;
    logic [RESID_W-1:0] resid_base;
    logic               first_base;
    logic [PACK_W-1:0]  pack_bytes;
    logic [3:0]         total;
    logic [FifoW-1:0]   fifo_out;

    always_comb begin
        sof       = (cx == '0) && (cy == '0);
        video     = (cx < screen_width) && (cy < screen_height);
        last_pix  = (cx == screen_width - 10'd1) && (cy == screen_height - 10'd1);
        push_fail = push_valid_q && !fifo_ready;
        // The tlast word still in the push stage means the frame already completed,
        // so a sof arriving in that same cycle is not an abort.
        tail_push = push_valid_q && push_last_q;
        abort     = (state_q == StCapture) && sof && !tail_push;
        start     = sof && enable && !push_fail;
        take      = video && !push_fail && (start || ((state_q == StCapture) && !sof));
    end

    // State machine: IDLE and DROP both wait for the next sof.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StDrop: begin
                if (sof) begin
                    state_d = enable ? StCapture : StIdle;
                end
            end
            StCapture: begin
                if (sof) begin
                    state_d = enable ? StCapture : StIdle;
                end else if (tail_push && fifo_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (push_fail) begin
            state_d = StDrop;
        end
    end

    // Packer: residual bytes sit at the bottom, the new pixel lands right above them.
    always_comb begin
        cnt_base     = start ? 3'd0 : cnt_q;
        resid_base   = start ? '0 : resid_q;
        first_base   = start ? 1'b1 : first_q;
        pack_bytes   = {{PIXEL_W{1'b0}}, resid_base}
                     | ({{RESID_W{1'b0}}, rgb} << {cnt_base, 3'b000});
        total        = {1'b0, cnt_base} + 4'd3;

        resid_d      = resid_q;
        cnt_d        = cnt_q;
        first_d      = first_q;
        push_valid_d = 1'b0;
        push_data_d  = push_data_q;
        push_last_d  = push_last_q;
        push_user_d  = push_user_q;

        if (push_fail || abort) begin
            resid_d = '0;
            cnt_d   = 3'd0;
        end
        if (start) begin
            first_d = 1'b1;
        end
        if (take) begin
            cnt_d = total[2:0];
            if (total[3]) begin
                push_valid_d = 1'b1;
                push_data_d  = pack_bytes[AXIS_W-1:0];
                push_last_d  = last_pix;
                push_user_d  = first_base;
                resid_d      = RESID_W'(pack_bytes[PACK_W-1:AXIS_W]);
                first_d      = 1'b0;
            end else begin
                resid_d = pack_bytes[RESID_W-1:0];
                first_d = first_base;
            end
        end

        overflow_d = abort || push_fail;
        dropped_d  = dropped_q;
        if (overflow_d && (dropped_q != 16'hFFFF)) begin
            dropped_d = dropped_q + 16'd1;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q      <= StIdle;
            resid_q      <= '0;
            cnt_q        <= 3'd0;
            first_q      <= 1'b0;
            push_valid_q <= 1'b0;
            push_data_q  <= '0;
            push_last_q  <= 1'b0;
            push_user_q  <= 1'b0;
            overflow_q   <= 1'b0;
            dropped_q    <= 16'd0;
        end else begin
            state_q      <= state_d;
            resid_q      <= resid_d;
            cnt_q        <= cnt_d;
            first_q      <= first_d;
            push_valid_q <= push_valid_d;
            push_data_q  <= push_data_d;
            push_last_q  <= push_last_d;
            push_user_q  <= push_user_d;
            overflow_q   <= overflow_d;
            dropped_q    <= dropped_d;
        end
    end

    axis_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FifoW)
    ) u_fifo (
        .clk      (aclk),
        .rst      (areset),
        .wr_valid (push_valid_q),
        .wr_data  ({push_user_q, push_last_q, push_data_q}),
        .wr_ready (fifo_ready),
        .rd_valid (m_axis_rgb_tvalid),
        .rd_data  (fifo_out),
        .rd_ready (m_axis_rgb_tready)
    );

    assign m_axis_rgb_tdata = fifo_out[AXIS_W-1:0];
    assign m_axis_rgb_tlast = fifo_out[AXIS_W];
    assign m_axis_rgb_tuser = fifo_out[AXIS_W+1];
    assign overflow         = overflow_q;
    assign dropped_frames   = dropped_q;

endmodule

// File: tb/tb_hdmi_capture.sv
// tb_hdmi_capture: scoreboard bench for hdmi_capture. Stimulus pushes expected
// {tuser, tlast, tdata} words into a queue; a negedge monitor pops and compares
// on every handshake and checks output stability while stalled.
module tb_hdmi_capture;
    import hdmi_pkg::*;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [23:0] rgb = '0;
    logic [9:0]  cx = 10'h3FF;
    logic [9:0]  cy = 10'h3FF;
    logic [9:0]  screen_width = 10'd16;
    logic [9:0]  screen_height = 10'd2;
    logic        enable = 1'b0;
    logic [63:0] tdata;
    logic        tvalid;
    logic        tready = 1'b1;
    logic        tlast;
    logic        tuser;
    logic        ovf;
    logic [15:0] dropped;

    always #5 aclk = ~aclk;

    hdmi_capture #(
        .FIFO_DEPTH (4)
    ) dut (
        .aclk              (aclk),
        .areset            (areset),
        .rgb               (rgb),
        .cx                (cx),
        .cy                (cy),
        .screen_width      (screen_width),
        .screen_height     (screen_height),
        .enable            (enable),
        .m_axis_rgb_tdata  (tdata),
        .m_axis_rgb_tvalid (tvalid),
        .m_axis_rgb_tready (tready),
        .m_axis_rgb_tlast  (tlast),
        .m_axis_rgb_tuser  (tuser),
        .overflow          (ovf),
        .dropped_frames    (dropped)
    );

    typedef logic [65:0] word_t;  // {tuser, tlast, tdata}

    word_t exp_q[$];
    word_t got_log[$];
    int    n_tests = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    ovf_pulses = 0;
    int    tlast_seen = 0;
    int    words_seen = 0;
    int    vld_cycles = 0;
    bit    arm_lat = 1'b0;
    int    t_first_valid = -1;
    int    t_pix2 = -1;
    bit    hold_pend = 1'b0;
    word_t hold_word;
    word_t mon_w;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string name, input word_t act, input word_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge aclk) begin
        if (!areset) begin
            mon_w = {tuser, tlast, tdata};
            if (ovf) ovf_pulses++;
            if (tvalid) vld_cycles++;
            if (hold_pend) begin
                check("hold_valid", 66'(tvalid), 66'd1);
                check("hold_word", mon_w, hold_word);
            end
            hold_pend = tvalid && !tready;
            hold_word = mon_w;
            if (arm_lat && tvalid) begin
                t_first_valid = cyc;
                arm_lat = 1'b0;
            end
            if (tvalid && tready) begin
                words_seen++;
                if (tlast) tlast_seen++;
                got_log.push_back(mon_w);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %h expected none", mon_w);
                end else begin
                    check("sb_word", mon_w, exp_q.pop_front());
                end
            end
        end else begin
            hold_pend = 1'b0;
        end
    end

    // Byte-stream reference: pixel n of a frame is 24'(seed + n), bytes in order.
    task automatic model_frame(input int w, input int h, input int seed, input int npix,
                               input int max_words);
        logic [63:0] acc;
        logic [23:0] p;
        int          nb;
        int          nw;
        bit          first;
        acc   = '0;
        nb    = 0;
        nw    = 0;
        first = 1'b1;
        for (int n = 0; n < npix; n++) begin
            p = 24'(seed + n);
            for (int b = 0; b < 3; b++) begin
                acc[8*nb +: 8] = p[8*b +: 8];
                nb++;
                if (nb == 8) begin
                    if (nw < max_words) begin
                        exp_q.push_back({first, (npix == w * h) && (n == npix - 1), acc});
                    end
                    nw++;
                    first = 1'b0;
                    nb    = 0;
                    acc   = '0;
                end
            end
        end
    endtask

    // rdy_from >= 0: tready low before that pixel index, high from it on.
    task automatic drive_frame(input int w, input int seed, input int npix,
                               input int rdy_from, input bit toggle);
        for (int n = 0; n < npix; n++) begin
            cx  = 10'(n % w);
            cy  = 10'(n / w);
            rgb = 24'(seed + n);
            if (toggle) tready = ~tready;
            else if (rdy_from >= 0) tready = (n >= rdy_from);
            if (n == 2) t_pix2 = cyc;
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic blank(input int k);
        cx = 10'h3FF;
        cy = 10'h3FF;
        repeat (k) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic drain(input string name, input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(posedge aclk);
            #1;
            k++;
        end
        check(name, 66'(exp_q.size()), 66'd0);
    endtask

    int snap_a;
    int snap_b;

    initial begin
        // Reset state
        repeat (3) @(posedge aclk);
        #3;
        check("rst_tvalid", 66'(tvalid), 66'd0);
        check("rst_outputs", {tuser, tlast, tdata}, 66'd0);
        check("rst_overflow", 66'(ovf), 66'd0);
        check("rst_dropped", 66'(dropped), 66'd0);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        blank(2);

        // 16x2 frame, pixels 1..32, tready high
        enable = 1'b1;
        tready = 1'b1;
        model_frame(16, 2, 1, 32, 99);
        got_log.delete();
        arm_lat = 1'b1;
        drive_frame(16, 1, 32, -1, 1'b0);
        blank(4);
        drain("f1_drain", 100);
        check("f1_count", 66'(got_log.size()), 66'd12);
        if (got_log.size() >= 12) begin
            check("f1_word0", got_log[0], {2'b10, 64'h0003000002000001});
            check("f1_word1", got_log[1], {2'b00, 64'h0600000500000400});
            check("f1_word2", got_log[2], {2'b00, 64'h0000080000070000});
            check("f1_word11_flags", 66'(got_log[11][65:64]), 66'd1);
        end
        check("f1_latency", 66'(t_first_valid - t_pix2), 66'd2);
        check("f1_dropped", 66'(dropped), 66'd0);

        // Same frame with tready low: four words fit, fifth push overflows
        tready = 1'b0;
        snap_a = tlast_seen;
        model_frame(16, 2, 32'h100, 32, 4);
        drive_frame(16, 32'h100, 32, -1, 1'b0);
        blank(2);
        check("ovf_pulses", 66'(ovf_pulses), 66'd1);
        check("ovf_dropped", 66'(dropped), 66'd1);
        check("ovf_buffered", 66'(exp_q.size()), 66'd4);
        check("ovf_tvalid", 66'(tvalid), 66'd1);
        tready = 1'b1;
        drain("ovf_drain", 50);
        check("ovf_no_tlast", 66'(tlast_seen - snap_a), 66'd0);
        model_frame(16, 2, 32'h200, 32, 99);
        drive_frame(16, 32'h200, 32, -1, 1'b0);
        blank(4);
        drain("after_ovf_drain", 100);

        // enable low at sof: frame ignored, then a normal frame
        enable = 1'b0;
        snap_a = vld_cycles;
        drive_frame(16, 32'h300, 32, -1, 1'b0);
        blank(4);
        check("dis_no_valid", 66'(vld_cycles - snap_a), 66'd0);
        check("dis_tvalid", 66'(tvalid), 66'd0);
        enable = 1'b1;
        model_frame(16, 2, 32'h400, 32, 99);
        drive_frame(16, 32'h400, 32, -1, 1'b0);
        blank(4);
        drain("en_drain", 100);

        // sof forced after five pixels
        model_frame(16, 2, 32'h500, 5, 99);
        model_frame(16, 2, 32'h600, 32, 99);
        drive_frame(16, 32'h500, 5, -1, 1'b0);
        drive_frame(16, 32'h600, 32, -1, 1'b0);
        blank(4);
        drain("abort_drain", 100);
        check("abort_dropped", 66'(dropped), 66'd2);
        check("abort_pulses", 66'(ovf_pulses), 66'd2);

        // Full FIFO with a pop in the same cycle as the fifth push
        tready = 1'b0;
        model_frame(16, 2, 32'h700, 32, 99);
        drive_frame(16, 32'h700, 32, 14, 1'b0);
        blank(4);
        drain("fullpop_drain", 100);
        check("fullpop_pulses", 66'(ovf_pulses), 66'd2);
        check("fullpop_dropped", 66'(dropped), 66'd2);

        // Larger frame with tready toggling every cycle
        screen_width  = 10'd64;
        screen_height = 10'd16;
        snap_a = tlast_seen;
        snap_b = words_seen;
        model_frame(64, 16, 32'h800, 1024, 9999);
        drive_frame(64, 32'h800, 1024, -1, 1'b1);
        blank(2);
        tready = 1'b1;
        drain("toggle_drain", 200);
        check("toggle_words", 66'(words_seen - snap_b),
              66'((1024 / PIXELS_PER_GROUP) * WORDS_PER_GROUP));
        check("toggle_tlast", 66'(tlast_seen - snap_a), 66'd1);
        check("toggle_pulses", 66'(ovf_pulses), 66'd2);

        // Reset mid-frame with two words buffered
        screen_width  = 10'd16;
        screen_height = 10'd2;
        blank(2);
        tready = 1'b0;
        drive_frame(16, 32'h900, 7, -1, 1'b0);
        check("mid_tvalid_before", 66'(tvalid), 66'd1);
        #2;
        areset = 1'b1;
        #1;
        check("mid_rst_tvalid", 66'(tvalid), 66'd0);
        check("mid_rst_outputs", {tuser, tlast, tdata}, 66'd0);
        check("mid_rst_dropped", 66'(dropped), 66'd0);
        check("mid_rst_overflow", 66'(ovf), 66'd0);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        tready = 1'b1;
        blank(2);
        model_frame(16, 2, 32'hA00, 32, 99);
        drive_frame(16, 32'hA00, 32, -1, 1'b0);
        blank(4);
        drain("post_rst_drain", 100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hdmi_capture.md
HDMI_CAPTURE -- requirements
Module: hdmi_capture

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, meaning output word buffer depth in 64-bit words (power of two, >=2).
REQ-002 aclk  input  1  sole clock; all logic rising-edge.
REQ-003 areset  input  1  asynchronous, active-high reset.
REQ-004 rgb  input  24  pixel sampled at (cx,cy) in the same cycle.
REQ-005 cx, cy  input  10 each  pixel coordinates from the video timing generator.
REQ-006 screen_width, screen_height  input  10 each  active area size; screen_width a multiple of 8.
REQ-007 enable  input  1  capture request, sampled only at start of frame.
REQ-008 m_axis_rgb_tdata  output  64  packed pixel bytes.
REQ-009 m_axis_rgb_tvalid / m_axis_rgb_tready  output / input  1 each  AXI-Stream handshake.
REQ-010 m_axis_rgb_tlast  output  1  last word of a complete frame.
REQ-011 m_axis_rgb_tuser  output  1  first word of a frame.
REQ-012 overflow  output  1  one-cycle pulse when a frame is aborted.
REQ-013 dropped_frames  output  16  saturating count of aborted frames.

Function
REQ-014 sof is (cx==0 && cy==0); video is (cx<screen_width && cy<screen_height); a pixel is taken only when video is high in state CAPTURE.
REQ-015 States: IDLE, CAPTURE, DROP; reset enters IDLE.
REQ-016 IDLE->CAPTURE on sof with enable=1; the sof pixel is the first packed pixel; sof with enable=0 stays IDLE.
REQ-017 Packing little-endian, byte-continuous: pixel n occupies stream bytes 3n..3n+2, bits [7:0] at the lowest byte; 8 pixels form exactly 3 words.
REQ-018 The packer holds 0..7 residual bytes; a word is pushed into the FIFO in the cycle after the pixel completing it is taken.
REQ-019 Latency: with the FIFO empty and tready=1, a completed word appears on m_axis_rgb_tdata with tvalid=1 two cycles after its completing pixel.
REQ-020 tuser=1 on the first word of each captured frame only; tlast=1 on the word completing pixel (screen_width-1, screen_height-1) only.
REQ-021 CAPTURE->IDLE after the tlast word is pushed; capture resumes at the next sof if enable=1.
REQ-022 sof while in CAPTURE before frame end: residual bytes discarded, frame aborted (no tlast), new frame starts at this pixel with tuser, overflow pulsed, dropped_frames incremented.
REQ-023 Push to a full FIFO: word discarded, residual cleared, overflow pulsed, dropped_frames incremented, state DROP.
REQ-024 DROP->CAPTURE on the next sof with enable=1, else DROP->IDLE on that sof.
REQ-025 Words already in the FIFO at abort are still delivered unchanged; no word is ever duplicated or reordered.
REQ-026 tdata/tlast/tuser held stable while tvalid=1 and tready=0; tvalid never deasserts without a handshake.
REQ-027 Simultaneous push and pop on a full FIFO is a legal push (no overflow).
REQ-028 dropped_frames saturates at 16'hFFFF.

Reset
REQ-029 areset asserted asynchronously clears: state IDLE, residual count 0, FIFO empty, tvalid 0, tdata 0, tlast 0, tuser 0, overflow 0, dropped_frames 0.
REQ-030 Reset mid-frame discards all buffered data; the first output after release carries tuser=1.
REQ-031 areset deassertion is synchronised by the instantiating design; the block takes no action until the first sof after release.

Structure
REQ-032 Package hdmi_pkg holds PIXEL_W=24, AXIS_W=64, PIXELS_PER_GROUP=8, WORDS_PER_GROUP=3, and the state encoding.
REQ-033 The buffer is a sub-module axis_word_fifo (AXIS_W+2 bits wide: tdata, tlast, tuser; FIFO_DEPTH entries, registered output).
REQ-034 The packer and state machine live in hdmi_capture.

Verification
REQ-035 16x2 frame, pixels 24'h000001..24'h000020, tready=1 -> 12 words; word0=64'h0003000002000001 tuser=1; word1=64'h0600000500000400; word11 tlast=1.
REQ-036 Same frame, tready=0 throughout -> 4 words buffered, overflow pulse on 5th push, dropped_frames=1, no tlast; next frame with tready=1 complete with tuser.
REQ-037 enable=0 at sof -> no tvalid for the whole frame; enable=1 at following sof -> normal frame.
REQ-038 sof forced after 5 pixels of a frame -> residual discarded, dropped_frames=1, next word has tuser=1 and starts at the sof pixel.
REQ-039 tready toggling 1/0 every cycle over 640x480 -> 115200 words in order, single tlast, zero overflow.
REQ-040 areset pulse mid-frame with 2 words in FIFO -> tvalid low immediately, outputs zero, next frame starts with tuser=1.
